// File: rtl/ahb_wait_sram_slave.sv
// AHB-Lite SRAM slave with WAIT_STATES wait cycles per OKAY data phase
// and a two-cycle ERROR response for misaligned or oversized transfers.
module ahb_wait_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            wait_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  write_reg;
  logic [1:0]            size_reg;

  logic          accept, legal, can_branch, load_rd, do_write;
  logic [3:0]    be;
  logic [IW-1:0] rd_idx, wr_idx;
  logic          unused_bits;

  assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};

  always_comb begin
    accept     = hsel & htrans[1] & hready_in & ~rst;
    legal      = (hsize == 3'd0) ||
                 (hsize == 3'd1 && !haddr[0]) ||
                 (hsize == 3'd2 && haddr[1:0] == 2'b00);
    can_branch = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR2);
    case (size_reg)
      2'd0:    be = 4'b0001 << addr_reg[1:0];
      2'd1:    be = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    wr_idx   = addr_reg[ADDR_WIDTH-1:2];
    do_write = (state_reg == S_DONE) && write_reg && !rst;
    // A zero-wait read is fetched on its accept edge, so it indexes with the live address
    rd_idx   = (state_reg == S_WAIT) ? wr_idx : haddr[ADDR_WIDTH-1:2];

    load_rd    = 1'b0;
    state_next = state_reg;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR2: begin
        hresp      = (state_reg == S_ERR2);
        state_next = S_IDLE;
        if (accept) begin
          if (!legal) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_next = S_DONE;
            load_rd    = !hwrite;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = S_DONE;
          load_rd    = !write_reg;
        end
      end
      S_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 1'b1;
        state_next = S_ERR2;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= (state_reg == S_WAIT && state_next == S_WAIT) ? wait_cnt_reg + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && can_branch) begin
      addr_reg  <= haddr[ADDR_WIDTH-1:0];
      write_reg <= hwrite;
      size_reg  <= hsize[1:0];
    end
  end

  // One byte-wide RAM per lane; a write completing on the same edge as a read fetch is forwarded
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (do_write && be[gi]) mem[wr_idx] <= hwdata[gi*8 +: 8];
      end

      always_ff @(posedge clk) begin
        if (rst)
          rd_byte_reg <= 8'd0;
        else if (load_rd)
          rd_byte_reg <= (do_write && be[gi] && wr_idx == rd_idx) ? hwdata[gi*8 +: 8] : mem[rd_idx];
      end

      assign hrdata[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ahb_wait_sram_slave.sv
// Directed bench: three slave instances (0, 1 and 3 wait states) on a shared bus,
// a vector table on the 1-wait instance, plus hand sequences for pipelining/reset.
module tb_ahb_wait_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1, hsel3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite, hready_in;
  logic [2:0]  hsize;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ro0, ro1, ro3, rs0, rs1, rs3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ahb_wait_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata0), .hreadyout(ro0), .hresp(rs0));

  ahb_wait_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata1), .hreadyout(ro1), .hresp(rs1));

  ahb_wait_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata3), .hreadyout(ro3), .hresp(rs3));

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    int          exp_waits;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic logic get_ro(input int d);
    return (d == 0) ? ro0 : (d == 1) ? ro1 : ro3;
  endfunction

  function automatic logic get_rs(input int d);
    return (d == 0) ? rs0 : (d == 1) ? rs1 : rs3;
  endfunction

  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata3;
  endfunction

  task automatic set_sel(input int d, input logic v);
    hsel0 = v && (d == 0);
    hsel1 = v && (d == 1);
    hsel3 = v && (d == 3);
  endtask

  // Single non-pipelined transfer; waits counts data-phase cycles with hreadyout low
  task automatic xfer(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rs, output int waits);
    @(negedge clk);
    set_sel(d, 1'b1);
    htrans = 2'd2; haddr = addr; hwrite = wr; hsize = sz; hready_in = 1'b1;
    @(negedge clk);
    set_sel(d, 1'b0);
    htrans = 2'd0; hwdata = wd;
    waits = 0;
    while (get_ro(d) == 1'b0 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = get_rd(d);
    rs = get_rs(d);
  endtask

  logic [31:0] rd;
  logic        rs;
  int          waits;

  initial begin
    vecs[0]  = '{"w_w00",    1'b1, 3'd2, 32'h0000_0000, 32'h0102_0304, 32'h0,         1'b0, 1};
    vecs[1]  = '{"w_w10",    1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[2]  = '{"r_w10",    1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1};
    vecs[3]  = '{"w_w10b",   1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344, 32'h0,         1'b0, 1};
    vecs[4]  = '{"w_b11",    1'b1, 3'd0, 32'h0000_0011, 32'hFFFF_AAFF, 32'h0,         1'b0, 1};
    vecs[5]  = '{"r_merge",  1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'h1122_AA44, 1'b0, 1};
    vecs[6]  = '{"r_mis02",  1'b0, 3'd2, 32'h0000_0002, 32'h0,         32'h1122_AA44, 1'b1, 1};
    vecs[7]  = '{"r_size3",  1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h1122_AA44, 1'b1, 1};
    vecs[8]  = '{"w_size3",  1'b1, 3'd3, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1};
    vecs[9]  = '{"w_mis02",  1'b1, 3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0,         1'b1, 1};
    vecs[10] = '{"r_w00",    1'b0, 3'd2, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0, 1};
    vecs[11] = '{"w_w14",    1'b1, 3'd2, 32'h0000_0014, 32'h5566_7788, 32'h0,         1'b0, 1};
    vecs[12] = '{"w_h16",    1'b1, 3'd1, 32'h0000_0016, 32'hBEEF_0000, 32'h0,         1'b0, 1};
    vecs[13] = '{"w_hmis15", 1'b1, 3'd1, 32'h0000_0015, 32'h0,         32'h0,         1'b1, 1};
    vecs[14] = '{"r_alias",  1'b0, 3'd2, 32'h0000_1014, 32'h0,         32'hBEEF_7788, 1'b0, 1};
    vecs[15] = '{"w_b17",    1'b1, 3'd0, 32'h0000_0017, 32'h1234_5678, 32'h0,         1'b0, 1};
    vecs[16] = '{"r_b14",    1'b0, 3'd0, 32'h0000_0014, 32'h0,         32'h12EF_7788, 1'b0, 1};
    vecs[17] = '{"r_h12",    1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'h1122_AA44, 1'b0, 1};

    rst = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; hsel3 = 1'b0;
    haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; hwdata = '0; hready_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 32'(ro1), 32'd1);
    chk("reset_resp", 32'(rs1), 32'd0);
    chk("reset_rdata", rdata1, 32'h0);

    for (int i = 0; i < 18; i++) begin
      xfer(1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, rs, waits);
      chk({vecs[i].name, "_resp"}, 32'(rs), 32'(vecs[i].exp_resp));
      chk({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      if (!vecs[i].wr) chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      $display("vec %0d %s wr=%0b addr=0x%08h resp=%0b waits=%0d rdata=0x%08h",
               i, vecs[i].name, vecs[i].wr, vecs[i].addr, rs, waits, rd);
    end

    // Zero-wait back-to-back write then read of the same word
    xfer(0, 1'b1, 3'd2, 32'h20, 32'h99, rd, rs, waits);
    chk("ws0_pre_waits", 32'(waits), 32'd0);
    @(negedge clk);
    hsel0 = 1'b1; htrans = 2'd2; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; hready_in = 1'b1;
    @(negedge clk);
    chk("b2b_wr_ready", 32'(ro0), 32'd1);
    hwdata = 32'h5; hwrite = 1'b0;
    @(negedge clk);
    chk("b2b_rd_ready", 32'(ro0), 32'd1);
    chk("b2b_rd_data", rdata0, 32'h5);
    hsel0 = 1'b0; htrans = 2'd0;
    @(negedge clk);
    chk("b2b_idle_ready", 32'(ro0), 32'd1);
    $display("b2b ws0 write/read 0x20 rdata=0x%08h", rdata0);

    // Three wait states, error bypasses waits, reset aborts a pending write
    xfer(3, 1'b1, 3'd2, 32'h30, 32'h11, rd, rs, waits);
    chk("ws3_wr_waits", 32'(waits), 32'd3);
    xfer(3, 1'b0, 3'd2, 32'h30, 32'h0, rd, rs, waits);
    chk("ws3_rd_waits", 32'(waits), 32'd3);
    chk("ws3_rd_data", rd, 32'h11);
    xfer(3, 1'b0, 3'd2, 32'h31, 32'h0, rd, rs, waits);
    chk("ws3_err_waits", 32'(waits), 32'd1);
    chk("ws3_err_resp", 32'(rs), 32'd1);
    @(negedge clk);
    hsel3 = 1'b1; htrans = 2'd2; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'h77;
    chk("abort_wait1_ready", 32'(ro3), 32'd0);
    @(negedge clk);
    chk("abort_wait2_ready", 32'(ro3), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ro3), 32'd1);
    chk("abort_resp", 32'(rs3), 32'd0);
    chk("abort_rdata", rdata3, 32'h0);
    xfer(3, 1'b0, 3'd2, 32'h30, 32'h0, rd, rs, waits);
    chk("abort_mem_kept", rd, 32'h11);
    $display("ws3 abort write 0x30 later read=0x%08h", rd);

    // No accept with hready_in low or with IDLE
    @(negedge clk);
    hsel1 = 1'b1; htrans = 2'd2; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; hready_in = 1'b0;
    @(negedge clk);
    chk("noacc_hrdy_ready", 32'(ro1), 32'd1);
    chk("noacc_hrdy_resp", 32'(rs1), 32'd0);
    hwdata = 32'h0; htrans = 2'd0; hready_in = 1'b1;
    @(negedge clk);
    chk("noacc_idle_ready", 32'(ro1), 32'd1);
    chk("noacc_idle_resp", 32'(rs1), 32'd0);
    hsel1 = 1'b0;
    xfer(1, 1'b0, 3'd2, 32'h10, 32'h0, rd, rs, waits);
    chk("noacc_mem_kept", rd, 32'h1122_AA44);
    $display("no-accept sequence read 0x10=0x%08h", rd);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_wait_sram_slave.md
AHB_WAIT_SRAM_SLAVE -- requirements
Module: ahb_wait_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address bits decoded; storage is 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15: wait cycles inserted in every OKAY data phase.
REQ-003 Single clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 hsel  input  1  slave select from the decoder.
REQ-007 haddr  input  32  byte address; only [ADDR_WIDTH-1:0] used.
REQ-008 htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-009 hwrite  input  1  1 write, 0 read.
REQ-010 hsize  input  3  0 byte, 1 halfword, 2 word; others illegal.
REQ-011 hwdata  input  32  write data, valid in the data phase.
REQ-012 hready_in  input  1  bus-wide HREADY; an address phase is accepted only when high.
REQ-013 hrdata  output  32  read data.
REQ-014 hreadyout  output  1  low extends the current data phase.
REQ-015 hresp  output  1  0 OKAY, 1 ERROR.

Function
REQ-016 Transfer accepted at a rising edge when hsel & htrans[1] & hready_in; haddr, hwrite and hsize are latched on that edge.
REQ-017 IDLE, BUSY, hsel low or hready_in low: no transfer is accepted, and the next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
REQ-018 Each accepted transfer is classified as illegal if any of these holds: hsize>2; hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0]!=0.
REQ-019 FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
REQ-020 IDLE: hreadyout=1, hresp=0.
REQ-021 IDLE, legal accept, WAIT_STATES>0 -> WAIT.
REQ-022 IDLE, legal accept, WAIT_STATES=0 -> DONE.
REQ-023 IDLE, illegal accept -> ERR1.
REQ-024 WAIT: hreadyout=0, hresp=0; a 4-bit counter counts WAIT_STATES cycles, then the FSM moves to DONE.
REQ-025 DONE: hreadyout=1, hresp=0; the transfer completes on this edge.
REQ-026 DONE, with a new accept on the same edge: the FSM branches exactly as from IDLE (back-to-back pipelining).
REQ-027 DONE, with no accept: the FSM returns to IDLE.
REQ-028 ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1.
REQ-029 ERR2 branches on a new accept exactly as DONE does; wait states never apply to ERROR responses.
REQ-030 Write: at the DONE edge, only the byte lanes selected by latched hsize/haddr[1:0] are written, from the same lanes of hwdata (little-endian); all other bytes are unchanged.
REQ-031 Read: in the DONE cycle, hrdata = the full 32-bit word at latched haddr[ADDR_WIDTH-1:2]; the master selects the lanes.
REQ-032 Read hazard: a read completing immediately after a write to the same word returns the post-write data.
REQ-033 hrdata holds its last value outside read DONE cycles.
REQ-034 An illegal transfer never modifies memory; an illegal read leaves hrdata unchanged.
REQ-035 Address bits above ADDR_WIDTH-1 are ignored, so the memory aliases.

Reset
REQ-036 rst high at a rising edge: FSM -> IDLE, counter=0, hreadyout=1, hresp=0, hrdata=0.
REQ-037 rst aborts any in-flight transfer, including a pending write; the aborted write is not performed.
REQ-038 Memory contents are not initialised by rst.
REQ-039 Transfers are not accepted on an edge where rst is high.

Verification
REQ-040 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase shows hreadyout low 1 cycle then high; read hrdata=0xDEADBEEF, hresp=0.
REQ-041 Byte write 0xAA at 0x11 over word 0x11223344 at 0x10 -> word read at 0x10 returns 0x1122AA44.
REQ-042 Word read at 0x02 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); memory is unchanged; hsize=3 gives the same result.
REQ-043 WAIT_STATES=0: back-to-back NONSEQ write 0x5 to 0x20 then read 0x20 -> hreadyout stays 1 throughout; the read returns 0x5.
REQ-044 WAIT_STATES=3: assert rst during the second wait cycle of a write of 0x77 to 0x30 -> hreadyout=1 next cycle; a later read of 0x30 returns the old value.
REQ-045 Assert hsel with NONSEQ while hready_in=0, then with IDLE -> no transfer is accepted; hreadyout=1, hresp=0, memory is unchanged.
